// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, load/store and memory-side signals of the shared memory port
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            if_req_valid, if_req_ready, if_rsp_valid;
  logic [AW-1:0]   if_addr;
  logic [DW-1:0]   if_rsp_data;
  logic            d_req_valid, d_req_ready, d_we, d_rsp_valid;
  logic [AW-1:0]   d_addr;
  logic [DW-1:0]   d_wdata, d_rsp_data;
  logic [DW/8-1:0] d_be;
  logic            mem_req_valid, mem_req_ready, mem_we, mem_rsp_valid;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata, mem_rsp_data;
  logic [DW/8-1:0] mem_be;
  logic            err;
  modport slave (
    input  if_req_valid, if_addr, d_req_valid, d_addr, d_we, d_wdata, d_be,
           mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output if_req_ready, if_rsp_valid, if_rsp_data, d_req_ready, d_rsp_valid, d_rsp_data,
           mem_req_valid, mem_addr, mem_we, mem_wdata, mem_be, err
  );
  modport master (
    output if_req_valid, if_addr, d_req_valid, d_addr, d_we, d_wdata, d_be,
           mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  if_req_ready, if_rsp_valid, if_rsp_data, d_req_ready, d_rsp_valid, d_rsp_data,
           mem_req_valid, mem_addr, mem_we, mem_wdata, mem_be, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one-outstanding memory port shared by fetch and load/store, D-priority with IF starvation guard
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_t;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  state_t state, state_nx;
  logic [3:0] starve_cnt, starve_nx;
  logic lock, lock_d, drop;
  logic idle, sel_d, hs, take, drop_nx, err_nx, if_rsp_nx, d_rsp_nx;
  always_comb begin
    idle = state == IDLE;
    sel_d = lock ? lock_d : bus.d_req_valid & (!bus.if_req_valid | starve_cnt != LIMIT);
    bus.mem_req_valid = !rst & idle & (sel_d ? bus.d_req_valid : bus.if_req_valid);
    bus.mem_addr = sel_d ? bus.d_addr : bus.if_addr;
    bus.mem_we = sel_d & bus.d_we;
    bus.mem_wdata = sel_d ? bus.d_wdata : '0;
    bus.mem_be = sel_d ? bus.d_be : '1;
    hs = bus.mem_req_valid & bus.mem_req_ready;
    bus.d_req_ready = hs & sel_d;
    bus.if_req_ready = hs & !sel_d;
    // a response owed to a transaction killed by reset is swallowed, never forwarded
    take = bus.mem_rsp_valid & !drop;
    drop_nx = drop & !bus.mem_rsp_valid;
    err_nx = bus.err | (idle & take);
    if_rsp_nx = take & (state == BUSY_IF);
    d_rsp_nx = take & (state == BUSY_D);
    starve_nx = (!bus.if_req_valid | bus.if_req_ready) ? '0
              : (bus.d_req_ready & starve_cnt != LIMIT) ? starve_cnt + 4'd1 : starve_cnt;
    state_nx = hs ? (sel_d ? BUSY_D : BUSY_IF) : (!idle & take) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      starve_cnt <= '0;
      lock <= 1'b0;
      lock_d <= 1'b0;
      drop <= (drop | !idle) & !bus.mem_rsp_valid;
      bus.err <= 1'b0;
      bus.if_rsp_valid <= 1'b0;
      bus.d_rsp_valid <= 1'b0;
      bus.if_rsp_data <= '0;
      bus.d_rsp_data <= '0;
    end else begin
      state <= state_nx;
      starve_cnt <= starve_nx;
      lock <= bus.mem_req_valid & !bus.mem_req_ready;
      lock_d <= sel_d;
      drop <= drop_nx;
      bus.err <= err_nx;
      bus.if_rsp_valid <= if_rsp_nx;
      bus.d_rsp_valid <= d_rsp_nx;
      if (if_rsp_nx) bus.if_rsp_data <= bus.mem_rsp_data;
      if (d_rsp_nx) bus.d_rsp_data <= bus.mem_rsp_data;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic against a transaction-level reference model
module tb_mem_port_arbiter;
  localparam int LIMIT = 4;
  logic clk = 0, rst = 1;
  int errors = 0, checks = 0;
  mem_port_arbiter_if bus ();
  mem_port_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(LIMIT)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_req_valid = 0; bus.if_addr = 0;
    bus.d_req_valid = 0; bus.d_addr = 0; bus.d_we = 0; bus.d_wdata = 0; bus.d_be = 0;
    bus.mem_req_ready = 0; bus.mem_rsp_valid = 0; bus.mem_rsp_data = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  // both requesters keep asking; memory answers one cycle after each accept
  task automatic run_grants(input int n, input int drop_at, output logic [15:0] g);
    int k = 0;
    bit resp = 0;
    g = '0;
    for (int c = 0; c < 100 && k < n; c++) begin
      bus.d_req_valid = 1; bus.d_we = 0; bus.d_addr = 32'h1000 + 32'(k); bus.d_be = 4'hf;
      bus.if_req_valid = !(resp && k == drop_at);
      bus.if_addr = 32'h2000 + 32'(k);
      bus.mem_req_ready = 1; bus.mem_rsp_valid = resp; bus.mem_rsp_data = 32'(k);
      @(negedge clk);
      resp = bus.d_req_ready | bus.if_req_ready;
      if (resp) begin
        g[k] = bus.if_req_ready;
        k++;
      end
      tick();
    end
    chk("grant_count", 64'(k), 64'(n));
    idle_inputs();
    bus.mem_rsp_valid = resp;
    tick();
    bus.mem_rsp_valid = 0;
    tick();
  endtask

  bit out, owner_d, lk, lk_d, ifp, dp, exp_if_rsp, exp_d_rsp, sel_d, v, acc, ifv;
  int timer, streak;
  logic [31:0] rdata, ia, da, dw, exp_data;
  logic dwe;
  logic [3:0] dbe;
  logic [15:0] g;

  initial begin
    idle_inputs();
    bus.if_req_valid = 1; bus.d_req_valid = 1; bus.mem_req_ready = 1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mem_valid", bus.mem_req_valid, 0);
    chk("rst_if_ready", bus.if_req_ready, 0);
    chk("rst_d_ready", bus.d_req_ready, 0);
    chk("rst_rsp_valid", {bus.if_rsp_valid, bus.d_rsp_valid}, 0);
    chk("rst_rsp_data", {bus.if_rsp_data, bus.d_rsp_data}, 0);
    chk("rst_err", bus.err, 0);
    tick();
    rst = 0;
    idle_inputs();
    tick();

    // single IF read, response three cycles after accept
    bus.if_req_valid = 1; bus.if_addr = 32'h100; bus.mem_req_ready = 1;
    @(negedge clk);
    chk("t1_if_ready", bus.if_req_ready, 1);
    chk("t1_d_ready", bus.d_req_ready, 0);
    chk("t1_addr", bus.mem_addr, 32'h100);
    chk("t1_be", bus.mem_be, 4'hf);
    chk("t1_we", bus.mem_we, 0);
    tick();
    idle_inputs();
    for (int c = 1; c <= 5; c++) begin
      bus.mem_rsp_valid = c == 3;
      bus.mem_rsp_data = c == 3 ? 32'hDEADBEEF : 32'h0;
      @(negedge clk);
      chk("t1_if_rsp", bus.if_rsp_valid, 64'(c == 4));
      chk("t1_d_rsp", bus.d_rsp_valid, 0);
      if (c >= 4) chk("t1_if_data", bus.if_rsp_data, 32'hDEADBEEF);
      tick();
    end

    do_reset();
    run_grants(10, -1, g);
    for (int k = 0; k < 10; k++) chk($sformatf("t2_grant%0d_is_if", k), g[k], 64'(k % 5 == 4));

    // store stalled by memory while IF arrives: payload must stay frozen on D
    do_reset();
    for (int c = 0; c < 6; c++) begin
      bus.d_req_valid = 1; bus.d_we = 1; bus.d_addr = 32'h200; bus.d_wdata = 32'h12345678; bus.d_be = 4'b0011;
      bus.if_req_valid = c >= 1; bus.if_addr = 32'h300;
      bus.mem_req_ready = c == 5;
      @(negedge clk);
      chk("t3_valid", bus.mem_req_valid, 1);
      chk("t3_payload", {bus.mem_addr, bus.mem_wdata}, {32'h200, 32'h12345678});
      chk("t3_we_be", {bus.mem_we, bus.mem_be}, {1'b1, 4'b0011});
      chk("t3_d_ready", bus.d_req_ready, 64'(c == 5));
      chk("t3_if_ready", bus.if_req_ready, 0);
      tick();
    end
    bus.d_req_valid = 0; bus.mem_rsp_valid = 1; bus.mem_rsp_data = 32'hA5;
    @(negedge clk);
    chk("t3_busy_if_ready", bus.if_req_ready, 0);
    chk("t3_busy_mem_valid", bus.mem_req_valid, 0);
    tick();
    bus.mem_rsp_valid = 0;
    @(negedge clk);
    chk("t3_d_ack", bus.d_rsp_valid, 1);
    chk("t3_d_ack_data", bus.d_rsp_data, 32'hA5);
    chk("t3_if_after_ack", bus.if_req_ready, 1);
    tick();
    idle_inputs();
    bus.mem_rsp_valid = 1; bus.mem_rsp_data = 32'h55;
    tick();
    bus.mem_rsp_valid = 0;
    @(negedge clk);
    chk("t3_if_rsp", {bus.if_rsp_valid, bus.d_rsp_valid}, 2'b10);
    chk("t3_if_data", bus.if_rsp_data, 32'h55);
    tick();

    // stray response in IDLE
    bus.mem_rsp_valid = 1; bus.mem_rsp_data = 32'h77;
    @(negedge clk);
    chk("t4_err_before", bus.err, 0);
    tick();
    bus.mem_rsp_valid = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t4_err_sticky", bus.err, 1);
      chk("t4_no_rsp", {bus.if_rsp_valid, bus.d_rsp_valid}, 0);
      tick();
    end
    do_reset();
    @(negedge clk);
    chk("t4_err_cleared", bus.err, 0);
    tick();

    // reset while a load is in flight; its late response must vanish
    bus.d_req_valid = 1; bus.d_addr = 32'h300; bus.mem_req_ready = 1;
    @(negedge clk);
    chk("t5_d_ready", bus.d_req_ready, 1);
    tick();
    idle_inputs();
    rst = 1;
    @(negedge clk);
    chk("t5_rst_mem_valid", bus.mem_req_valid, 0);
    tick();
    rst = 0;
    bus.if_req_valid = 1; bus.if_addr = 32'h400; bus.mem_req_ready = 1;
    @(negedge clk);
    chk("t5_if_ready_after_rst", bus.if_req_ready, 1);
    tick();
    idle_inputs();
    for (int c = 3; c <= 7; c++) begin
      bus.mem_rsp_valid = c == 4 || c == 6;
      bus.mem_rsp_data = c == 4 ? 32'hBAD : 32'hCAFE;
      @(negedge clk);
      chk("t5_d_rsp", bus.d_rsp_valid, 0);
      chk("t5_if_rsp", bus.if_rsp_valid, 64'(c == 7));
      if (c == 7) chk("t5_if_data", bus.if_rsp_data, 32'hCAFE);
      chk("t5_err", bus.err, 0);
      tick();
    end

    // IF valid drops after three contested D wins: starvation count starts over
    do_reset();
    run_grants(8, 3, g);
    for (int k = 0; k < 8; k++) chk($sformatf("t6_grant%0d_is_if", k), g[k], 64'(k == 7));

    // randomized traffic against a transaction-level model
    do_reset();
    out = 0; lk = 0; lk_d = 0; ifp = 0; dp = 0; exp_if_rsp = 0; exp_d_rsp = 0; streak = 0;
    owner_d = 0; timer = 0; rdata = 0; ia = 0; da = 0; dw = 0; dwe = 0; dbe = 0; exp_data = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!ifp && $urandom_range(0, 2) == 0) begin ifp = 1; ia = $urandom; end
      if (!dp && $urandom_range(0, 2) == 0) begin
        dp = 1; da = $urandom; dw = $urandom; dwe = 1'($urandom); dbe = 4'($urandom);
      end
      bus.if_req_valid = ifp; bus.if_addr = ia;
      bus.d_req_valid = dp; bus.d_addr = da; bus.d_wdata = dw; bus.d_we = dwe; bus.d_be = dbe;
      bus.mem_req_ready = $urandom_range(0, 3) != 0;
      bus.mem_rsp_valid = out && timer == 0;
      bus.mem_rsp_data = rdata;
      @(negedge clk);
      chk("rnd_if_rsp", bus.if_rsp_valid, 64'(exp_if_rsp));
      chk("rnd_d_rsp", bus.d_rsp_valid, 64'(exp_d_rsp));
      if (exp_if_rsp) chk("rnd_if_data", bus.if_rsp_data, exp_data);
      if (exp_d_rsp) chk("rnd_d_data", bus.d_rsp_data, exp_data);
      sel_d = lk ? lk_d : dp && !(ifp && streak == LIMIT);
      v = !out && (sel_d ? dp : ifp);
      chk("rnd_mem_valid", bus.mem_req_valid, 64'(v));
      if (v) begin
        chk("rnd_addr", bus.mem_addr, sel_d ? da : ia);
        chk("rnd_we", bus.mem_we, 64'(sel_d & dwe));
        chk("rnd_wdata", bus.mem_wdata, sel_d ? dw : 32'h0);
        chk("rnd_be", bus.mem_be, sel_d ? dbe : 4'hf);
      end
      acc = v && bus.mem_req_ready;
      chk("rnd_if_ready", bus.if_req_ready, 64'(acc && !sel_d));
      chk("rnd_d_ready", bus.d_req_ready, 64'(acc && sel_d));
      chk("rnd_err", bus.err, 0);
      ifv = ifp;
      exp_if_rsp = bus.mem_rsp_valid && !owner_d;
      exp_d_rsp = bus.mem_rsp_valid && owner_d;
      if (bus.mem_rsp_valid) begin
        exp_data = rdata;
        out = 0;
      end else if (out) timer--;
      if (acc) begin
        out = 1; owner_d = sel_d; timer = $urandom_range(0, 3); rdata = $urandom;
        if (sel_d) dp = 0; else ifp = 0;
      end
      if (!ifv || (acc && !sel_d)) streak = 0;
      else if (acc) streak = streak == LIMIT ? LIMIT : streak + 1;
      lk = v && !bus.mem_req_ready;
      lk_d = sel_d;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
